// File: rtl/hwpe_stream_deserialize_rr.sv
// Round-robin deserializer: spreads one time-multiplexed HWPE stream over
// NB_STREAMS outputs, nb_contig_m1_i+1 consecutive beats per stream.
module hwpe_stream_deserialize_rr #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NB_STREAMS = 4,
  parameter int unsigned SW         = 10
) (
  input  logic                             clk_i,
  input  logic                             clear_i,
  input  logic [DATA_WIDTH-1:0]            push_data_i,
  input  logic [DATA_WIDTH/8-1:0]          push_strb_i,
  input  logic                             push_valid_i,
  output logic                             push_ready_o,
  output logic [NB_STREAMS*DATA_WIDTH-1:0] pop_data_o,
  output logic [NB_STREAMS*DATA_WIDTH/8-1:0] pop_strb_o,
  output logic [NB_STREAMS-1:0]            pop_valid_o,
  input  logic [NB_STREAMS-1:0]            pop_ready_i,
  input  logic [SW-1:0]                    first_stream_i,
  input  logic                             clear_serdes_state_i,
  input  logic [SW-1:0]                    nb_contig_m1_i,
  output logic [SW-1:0]                    flags_stream_o,
  output logic [SW-1:0]                    flags_cnt_o
);

  localparam logic [SW-1:0] LAST_STREAM    = SW'(NB_STREAMS - 1);
  localparam logic [SW:0]   NB_STREAMS_EXT = (SW + 1)'(NB_STREAMS);

  logic [SW-1:0] stream_q;
  logic [SW-1:0] cnt_q;
  logic          blocked;
  logic          sel_ready;
  logic          hs;

  assign blocked = clear_i | clear_serdes_state_i;

  // Decode by comparison so the index never outgrows the per-stream vectors.
  always_comb begin
    sel_ready   = 1'b0;
    pop_valid_o = '0;
    for (int unsigned k = 0; k < NB_STREAMS; k++) begin
      if (stream_q == SW'(k)) begin
        sel_ready      = pop_ready_i[k];
        pop_valid_o[k] = push_valid_i & ~blocked;
      end
    end
  end

  assign push_ready_o = sel_ready & ~blocked;
  assign hs           = push_valid_i & push_ready_o;

  assign pop_data_o = {NB_STREAMS{push_data_i}};
  assign pop_strb_o = {NB_STREAMS{push_strb_i}};

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      stream_q <= '0;
      cnt_q    <= '0;
    end else if (clear_serdes_state_i) begin
      stream_q <= ({1'b0, first_stream_i} >= NB_STREAMS_EXT) ? '0 : first_stream_i;
      cnt_q    <= '0;
    end else if (hs) begin
      // >= so a group shortened mid-flight still advances on the next beat
      if (cnt_q >= nb_contig_m1_i) begin
        cnt_q    <= '0;
        stream_q <= (stream_q == LAST_STREAM) ? '0 : stream_q + SW'(1);
      end else begin
        cnt_q <= cnt_q + SW'(1);
      end
    end
  end

  assign flags_stream_o = stream_q;
  assign flags_cnt_o    = cnt_q;

endmodule

// File: tb/tb_hwpe_stream_deserialize_rr.sv
// Self-checking bench for hwpe_stream_deserialize_rr: directed scenarios on a
// 4-stream instance, randomized scoreboard run on a 3-stream instance.
module tb_hwpe_stream_deserialize_rr;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] push_data;
  logic [3:0]  push_strb;
  logic        push_valid;
  logic [9:0]  first_stream;
  logic        clear_serdes;
  logic [9:0]  contig;

  logic         push_ready4;
  logic [127:0] pop_data4;
  logic [15:0]  pop_strb4;
  logic [3:0]   pop_valid4;
  logic [3:0]   pop_ready4;
  logic [9:0]   flags_stream4;
  logic [9:0]   flags_cnt4;

  logic        push_ready3;
  logic [95:0] pop_data3;
  logic [11:0] pop_strb3;
  logic [2:0]  pop_valid3;
  logic [2:0]  pop_ready3;
  logic [9:0]  flags_stream3;
  logic [9:0]  flags_cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hwpe_stream_deserialize_rr #(.DATA_WIDTH(32), .NB_STREAMS(4), .SW(10)) dut4 (
    .clk_i(clk), .clear_i(clear),
    .push_data_i(push_data), .push_strb_i(push_strb),
    .push_valid_i(push_valid), .push_ready_o(push_ready4),
    .pop_data_o(pop_data4), .pop_strb_o(pop_strb4),
    .pop_valid_o(pop_valid4), .pop_ready_i(pop_ready4),
    .first_stream_i(first_stream), .clear_serdes_state_i(clear_serdes),
    .nb_contig_m1_i(contig),
    .flags_stream_o(flags_stream4), .flags_cnt_o(flags_cnt4)
  );

  hwpe_stream_deserialize_rr #(.DATA_WIDTH(32), .NB_STREAMS(3), .SW(10)) dut3 (
    .clk_i(clk), .clear_i(clear),
    .push_data_i(push_data), .push_strb_i(push_strb),
    .push_valid_i(push_valid), .push_ready_o(push_ready3),
    .pop_data_o(pop_data3), .pop_strb_o(pop_strb3),
    .pop_valid_o(pop_valid3), .pop_ready_i(pop_ready3),
    .first_stream_i(first_stream), .clear_serdes_state_i(clear_serdes),
    .nb_contig_m1_i(contig),
    .flags_stream_o(flags_stream3), .flags_cnt_o(flags_cnt3)
  );

  task automatic test_reset();
    clear = 1'b1; push_valid = 1'b1; push_data = 32'hdead_beef; push_strb = 4'hf;
    pop_ready4 = '1; pop_ready3 = '1; clear_serdes = 1'b0; first_stream = '0; contig = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (push_ready4 !== 1'b0) begin n_fail++; $display("FAIL reset_push_ready: got %0b expected 0", push_ready4); end
    n_checks++; if (pop_valid4 !== 4'b0) begin n_fail++; $display("FAIL reset_pop_valid: got %b expected 0000", pop_valid4); end
    n_checks++; if (flags_stream4 !== 10'd0) begin n_fail++; $display("FAIL reset_flags_stream: got %0d expected 0", flags_stream4); end
    n_checks++; if (flags_cnt4 !== 10'd0) begin n_fail++; $display("FAIL reset_flags_cnt: got %0d expected 0", flags_cnt4); end
    n_checks++; if (pop_valid3 !== 3'b0) begin n_fail++; $display("FAIL reset_pop_valid3: got %b expected 000", pop_valid3); end
    clear = 1'b0; push_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    int e;
    contig = 10'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      push_data = 32'(i); push_strb = 4'($urandom); push_valid = 1'b1; pop_ready4 = '1;
      #1;
      e = i % 4;
      n_checks++; if (flags_stream4 !== 10'(e)) begin n_fail++; $display("FAIL rr_stream beat %0d: got %0d expected %0d", i, flags_stream4, e); end
      n_checks++; if (pop_valid4 !== 4'(1 << e)) begin n_fail++; $display("FAIL rr_valid beat %0d: got %b expected %b", i, pop_valid4, 4'(1 << e)); end
      n_checks++; if (pop_data4[e*32 +: 32] !== 32'(i)) begin n_fail++; $display("FAIL rr_data beat %0d: got %0h expected %0h", i, pop_data4[e*32 +: 32], i); end
      n_checks++; if (pop_strb4[e*4 +: 4] !== push_strb) begin n_fail++; $display("FAIL rr_strb beat %0d: got %h expected %h", i, pop_strb4[e*4 +: 4], push_strb); end
    end
    @(negedge clk); push_valid = 1'b0;
  endtask

  task automatic test_contig();
    int e;
    @(negedge clk);
    clear_serdes = 1'b1; first_stream = 10'd1; contig = 10'd2; push_valid = 1'b1; push_data = 32'hbad;
    #1;
    n_checks++; if (push_ready4 !== 1'b0) begin n_fail++; $display("FAIL contig_load_ready: got %0b expected 0", push_ready4); end
    n_checks++; if (pop_valid4 !== 4'b0) begin n_fail++; $display("FAIL contig_load_valid: got %b expected 0000", pop_valid4); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      clear_serdes = 1'b0; push_data = 32'(100 + i);
      #1;
      e = (1 + i / 3) % 4;
      n_checks++; if (flags_stream4 !== 10'(e)) begin n_fail++; $display("FAIL contig_stream beat %0d: got %0d expected %0d", i, flags_stream4, e); end
      n_checks++; if (flags_cnt4 !== 10'(i % 3)) begin n_fail++; $display("FAIL contig_cnt beat %0d: got %0d expected %0d", i, flags_cnt4, i % 3); end
      n_checks++; if (pop_valid4 !== 4'(1 << e)) begin n_fail++; $display("FAIL contig_valid beat %0d: got %b expected %b", i, pop_valid4, 4'(1 << e)); end
      n_checks++; if (pop_data4[e*32 +: 32] !== 32'(100 + i)) begin n_fail++; $display("FAIL contig_data beat %0d: got %0h expected %0h", i, pop_data4[e*32 +: 32], 100 + i); end
    end
    @(negedge clk); push_valid = 1'b0; #1;
    n_checks++; if (flags_stream4 !== 10'd0 || flags_cnt4 !== 10'd0) begin n_fail++; $display("FAIL contig_wrap: got %0d/%0d expected 0/0", flags_stream4, flags_cnt4); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); clear_serdes = 1'b1; first_stream = 10'd0; contig = 10'd0; push_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); clear_serdes = 1'b0; push_valid = 1'b1; push_data = 32'(200 + i); pop_ready4 = '1;
      #1;
      n_checks++; if (pop_valid4 !== 4'(1 << i)) begin n_fail++; $display("FAIL bp_pre_valid beat %0d: got %b expected %b", i, pop_valid4, 4'(1 << i)); end
    end
    @(negedge clk); push_data = 32'd202; pop_ready4 = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (push_ready4 !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d: got %0b expected 0", c, push_ready4); end
      n_checks++; if (pop_valid4 !== 4'b0100) begin n_fail++; $display("FAIL bp_valid cycle %0d: got %b expected 0100", c, pop_valid4); end
      n_checks++; if (flags_stream4 !== 10'd2) begin n_fail++; $display("FAIL bp_stream cycle %0d: got %0d expected 2", c, flags_stream4); end
      @(negedge clk);
    end
    pop_ready4 = '1; #1;
    n_checks++; if (push_ready4 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b expected 1", push_ready4); end
    n_checks++; if (pop_data4[64 +: 32] !== 32'd202) begin n_fail++; $display("FAIL bp_release_data: got %0h expected ca", pop_data4[64 +: 32]); end
    @(negedge clk); push_valid = 1'b0; #1;
    n_checks++; if (flags_stream4 !== 10'd3) begin n_fail++; $display("FAIL bp_advance: got %0d expected 3", flags_stream4); end
  endtask

  task automatic test_first_stream_oob();
    @(negedge clk); contig = 10'd2; push_valid = 1'b1; push_data = 32'd300; #1;
    n_checks++; if (pop_valid4 !== 4'b1000) begin n_fail++; $display("FAIL oob_pre_valid: got %b expected 1000", pop_valid4); end
    @(negedge clk); clear_serdes = 1'b1; first_stream = 10'd7; push_data = 32'd301; #1;
    n_checks++; if (flags_cnt4 !== 10'd1) begin n_fail++; $display("FAIL oob_pre_cnt: got %0d expected 1", flags_cnt4); end
    n_checks++; if (push_ready4 !== 1'b0) begin n_fail++; $display("FAIL oob_blocked_ready: got %0b expected 0", push_ready4); end
    n_checks++; if (pop_valid4 !== 4'b0) begin n_fail++; $display("FAIL oob_blocked_valid: got %b expected 0000", pop_valid4); end
    @(negedge clk); clear_serdes = 1'b0; push_valid = 1'b0; #1;
    n_checks++; if (flags_stream4 !== 10'd0) begin n_fail++; $display("FAIL oob_stream: got %0d expected 0", flags_stream4); end
    n_checks++; if (flags_cnt4 !== 10'd0) begin n_fail++; $display("FAIL oob_cnt: got %0d expected 0", flags_cnt4); end
  endtask

  task automatic test_clear_mid();
    @(negedge clk); clear_serdes = 1'b1; first_stream = 10'd1; contig = 10'd2;
    @(negedge clk); clear_serdes = 1'b0; push_valid = 1'b1; push_data = 32'd400;
    @(negedge clk); push_data = 32'd401; #1;
    n_checks++; if (flags_stream4 !== 10'd1 || flags_cnt4 !== 10'd1) begin n_fail++; $display("FAIL clr_pre_flags: got %0d/%0d expected 1/1", flags_stream4, flags_cnt4); end
    @(negedge clk); clear = 1'b1; push_data = 32'd402; #1;
    n_checks++; if (push_ready4 !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %0b expected 0", push_ready4); end
    n_checks++; if (pop_valid4 !== 4'b0) begin n_fail++; $display("FAIL clr_valid: got %b expected 0000", pop_valid4); end
    @(negedge clk); clear = 1'b0; #1;
    n_checks++; if (flags_stream4 !== 10'd0 || flags_cnt4 !== 10'd0) begin n_fail++; $display("FAIL clr_flags: got %0d/%0d expected 0/0", flags_stream4, flags_cnt4); end
    n_checks++; if (pop_valid4 !== 4'b0001) begin n_fail++; $display("FAIL clr_next_valid: got %b expected 0001", pop_valid4); end
    n_checks++; if (pop_data4[31:0] !== 32'd402) begin n_fail++; $display("FAIL clr_next_data: got %0h expected 192", pop_data4[31:0]); end
    @(negedge clk); push_valid = 1'b0; #1;
    n_checks++; if (flags_stream4 !== 10'd0 || flags_cnt4 !== 10'd1) begin n_fail++; $display("FAIL clr_after: got %0d/%0d expected 0/1", flags_stream4, flags_cnt4); end
  endtask

  task automatic test_random();
    logic [35:0] sbq [3][$];
    logic [35:0] got, exp;
    logic [31:0] cur_data;
    logic [3:0]  cur_strb;
    logic        have, exp_hs;
    int acc, cyc, e;
    have = 1'b0; acc = 0; cyc = 0; cur_data = '0; cur_strb = '0;
    @(negedge clk); clear = 1'b1; contig = 10'd1; first_stream = '0; clear_serdes = 1'b0; push_valid = 1'b0;
    @(negedge clk); clear = 1'b0;
    while (acc < 10000 && cyc < 60000) begin
      @(negedge clk); cyc++;
      if (!have && $urandom_range(3) != 0) begin
        cur_data = $urandom; cur_strb = 4'($urandom); have = 1'b1;
      end
      push_valid = have; push_data = cur_data; push_strb = cur_strb;
      pop_ready3 = 3'($urandom); pop_ready4 = 4'($urandom);
      #1;
      e = (acc / 2) % 3;
      n_checks++; if (pop_valid3 !== (have ? 3'(1 << e) : 3'b0)) begin n_fail++; $display("FAIL rnd_valid beat %0d: got %b expected %b", acc, pop_valid3, have ? 3'(1 << e) : 3'b0); end
      n_checks++; if (flags_stream3 !== 10'(e) || flags_cnt3 !== 10'(acc % 2)) begin n_fail++; $display("FAIL rnd_flags beat %0d: got %0d/%0d expected %0d/%0d", acc, flags_stream3, flags_cnt3, e, acc % 2); end
      n_checks++; if (push_ready3 !== pop_ready3[e]) begin n_fail++; $display("FAIL rnd_ready beat %0d: got %0b expected %0b", acc, push_ready3, pop_ready3[e]); end
      exp_hs = have && pop_ready3[e];
      if (exp_hs) sbq[e].push_back({cur_strb, cur_data});
      for (int k = 0; k < 3; k++) begin
        if (pop_valid3[k] && pop_ready3[k]) begin
          n_checks++;
          if (sbq[k].size() == 0) begin
            n_fail++; $display("FAIL rnd_unexpected stream %0d: got beat %h expected none", k, {pop_strb3[k*4 +: 4], pop_data3[k*32 +: 32]});
          end else begin
            got = {pop_strb3[k*4 +: 4], pop_data3[k*32 +: 32]};
            exp = sbq[k].pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL rnd_data stream %0d: got %h expected %h", k, got, exp); end
          end
        end
      end
      if (exp_hs) begin acc++; have = 1'b0; end
    end
    @(negedge clk); push_valid = 1'b0;
    n_checks++; if (acc < 10000) begin n_fail++; $display("FAIL rnd_timeout: got %0d beats expected 10000", acc); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (sbq[k].size() != 0) begin n_fail++; $display("FAIL rnd_leftover stream %0d: got %0d pending expected 0", k, sbq[k].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_contig();
    test_backpressure();
    test_first_stream_oob();
    test_clear_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
